// File: rtl/usb_rx_controller.sv
// USB device transaction sequencer: steers received OUT data into the RX FIFO,
// answers IN tokens from the TX FIFO and tracks the host handshake.
module usb_rx_controller #(
    parameter int TIMEOUT_CYCLES = 288
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       in_token,
    input  logic       out_token,
    input  logic       byte_ready,
    input  logic [7:0] data_byte,
    input  logic       eop_found,
    input  logic       crc_err,
    input  logic       host_ack,
    input  logic       host_nack,
    input  logic       rx_fifo_full,
    input  logic       tx_data_avail,
    input  logic       tx_done,
    output logic       rx_fifo_wr,
    output logic [7:0] rx_fifo_wdata,
    output logic       rx_commit,
    output logic       rx_rollback,
    output logic       tx_send_ack,
    output logic       tx_send_nak,
    output logic       tx_send_data,
    output logic       tx_pkt_release,
    output logic       tx_pkt_retry,
    output logic       proto_err
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        OUT_TOK,
        OUT_DATA,
        OUT_RESP,
        IN_RESP,
        WAIT_HS
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          dirty_q;
    logic          in_sent_q;
    logic          in_data_q;
    logic          pend_in_q;
    logic          pend_out_q;

    logic          wr_q;
    logic [7:0]    wdata_q;
    logic          commit_q;
    logic          rollback_q;
    logic          send_ack_q;
    logic          send_nak_q;
    logic          send_data_q;
    logic          release_q;
    logic          retry_q;
    logic          perr_q;

    logic          tok_any;
    logic          tok_in;
    logic          tok_out;
    logic          pend_any;
    logic          abort;

    always_comb begin
        tok_any  = in_token | out_token;
        tok_in   = in_token | pend_in_q;
        tok_out  = out_token | pend_out_q;
        pend_any = pend_in_q | pend_out_q;
        abort    = tok_any && (state_q == OUT_TOK ||
                               state_q == IN_RESP ||
                               state_q == WAIT_HS);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            dirty_q     <= 1'b0;
            in_sent_q   <= 1'b0;
            in_data_q   <= 1'b0;
            pend_in_q   <= 1'b0;
            pend_out_q  <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            commit_q    <= 1'b0;
            rollback_q  <= 1'b0;
            send_ack_q  <= 1'b0;
            send_nak_q  <= 1'b0;
            send_data_q <= 1'b0;
            release_q   <= 1'b0;
            retry_q     <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            wr_q        <= 1'b0;
            commit_q    <= 1'b0;
            rollback_q  <= 1'b0;
            send_ack_q  <= 1'b0;
            send_nak_q  <= 1'b0;
            send_data_q <= 1'b0;
            release_q   <= 1'b0;
            retry_q     <= 1'b0;

            // A token mid-transaction is replayed from IDLE on the next cycle
            if (abort) begin
                perr_q     <= 1'b1;
                pend_in_q  <= in_token;
                pend_out_q <= out_token;
                state_q    <= IDLE;
                if (dirty_q) begin
                    rollback_q <= 1'b1;
                    dirty_q    <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        pend_in_q  <= 1'b0;
                        pend_out_q <= 1'b0;
                        if (tok_in && tok_out) begin
                            perr_q <= 1'b1;
                        end else if (tok_out) begin
                            ovf_q   <= 1'b0;
                            state_q <= OUT_TOK;
                            if (!pend_any) perr_q <= 1'b0;
                        end else if (tok_in) begin
                            in_sent_q <= 1'b0;
                            in_data_q <= 1'b0;
                            state_q   <= IN_RESP;
                            if (!pend_any) perr_q <= 1'b0;
                        end
                    end

                    OUT_TOK: begin
                        if (eop_found) begin
                            if (crc_err) begin
                                perr_q  <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                state_q <= OUT_DATA;
                            end
                        end
                    end

                    OUT_DATA: begin
                        if (eop_found) begin
                            dirty_q <= 1'b0;
                            if (crc_err) begin
                                rollback_q <= 1'b1;
                                state_q    <= IDLE;
                            end else if (ovf_q) begin
                                rollback_q <= 1'b1;
                                send_nak_q <= 1'b1;
                                state_q    <= OUT_RESP;
                            end else begin
                                commit_q   <= 1'b1;
                                send_ack_q <= 1'b1;
                                state_q    <= OUT_RESP;
                            end
                        end else if (byte_ready) begin
                            // Once a byte is dropped the rest of the packet is dropped too
                            if (rx_fifo_full || ovf_q) begin
                                ovf_q <= 1'b1;
                            end else begin
                                wr_q    <= 1'b1;
                                wdata_q <= data_byte;
                                dirty_q <= 1'b1;
                            end
                        end
                    end

                    OUT_RESP: begin
                        if (tx_done) state_q <= IDLE;
                    end

                    IN_RESP: begin
                        if (!in_sent_q) begin
                            if (eop_found) begin
                                if (crc_err) begin
                                    state_q <= IDLE;
                                end else if (tx_data_avail) begin
                                    send_data_q <= 1'b1;
                                    in_sent_q   <= 1'b1;
                                    in_data_q   <= 1'b1;
                                end else begin
                                    send_nak_q <= 1'b1;
                                    in_sent_q  <= 1'b1;
                                    in_data_q  <= 1'b0;
                                end
                            end
                        end else if (tx_done) begin
                            if (in_data_q) begin
                                cnt_q   <= CNT_LOAD;
                                state_q <= WAIT_HS;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end

                    WAIT_HS: begin
                        if (host_ack) begin
                            release_q <= 1'b1;
                            state_q   <= IDLE;
                        end else if (host_nack) begin
                            retry_q <= 1'b1;
                            state_q <= IDLE;
                        end else if (cnt_q == '0) begin
                            retry_q <= 1'b1;
                            perr_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end

                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rx_fifo_wr     = wr_q;
    assign rx_fifo_wdata  = wdata_q;
    assign rx_commit      = commit_q;
    assign rx_rollback    = rollback_q;
    assign tx_send_ack    = send_ack_q;
    assign tx_send_nak    = send_nak_q;
    assign tx_send_data   = send_data_q;
    assign tx_pkt_release = release_q;
    assign tx_pkt_retry   = retry_q;
    assign proto_err      = perr_q;

endmodule

// File: tb/tb_usb_rx_controller.sv
// Scenario bench for usb_rx_controller: directed transactions plus
// randomized OUT packets checked against a packet-level model.
module tb_usb_rx_controller;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       in_token = 1'b0;
    logic       out_token = 1'b0;
    logic       byte_ready = 1'b0;
    logic [7:0] data_byte = 8'h00;
    logic       eop_found = 1'b0;
    logic       crc_err = 1'b0;
    logic       host_ack = 1'b0;
    logic       host_nack = 1'b0;
    logic       rx_fifo_full = 1'b0;
    logic       tx_data_avail = 1'b0;
    logic       tx_done = 1'b0;
    logic       rx_fifo_wr;
    logic [7:0] rx_fifo_wdata;
    logic       rx_commit;
    logic       rx_rollback;
    logic       tx_send_ack;
    logic       tx_send_nak;
    logic       tx_send_data;
    logic       tx_pkt_release;
    logic       tx_pkt_retry;
    logic       proto_err;

    usb_rx_controller #(.TIMEOUT_CYCLES(288)) dut (
        .clk(clk), .n_rst(n_rst),
        .in_token(in_token), .out_token(out_token),
        .byte_ready(byte_ready), .data_byte(data_byte),
        .eop_found(eop_found), .crc_err(crc_err),
        .host_ack(host_ack), .host_nack(host_nack),
        .rx_fifo_full(rx_fifo_full), .tx_data_avail(tx_data_avail),
        .tx_done(tx_done),
        .rx_fifo_wr(rx_fifo_wr), .rx_fifo_wdata(rx_fifo_wdata),
        .rx_commit(rx_commit), .rx_rollback(rx_rollback),
        .tx_send_ack(tx_send_ack), .tx_send_nak(tx_send_nak),
        .tx_send_data(tx_send_data),
        .tx_pkt_release(tx_pkt_release), .tx_pkt_retry(tx_pkt_retry),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    wire [17:0] all_out = {rx_fifo_wr, rx_fifo_wdata, rx_commit, rx_rollback,
                           tx_send_ack, tx_send_nak, tx_send_data,
                           tx_pkt_release, tx_pkt_retry, proto_err};

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // event index: 0 commit 1 rollback 2 ack 3 nak 4 data 5 release 6 retry
    int n_ev[7] = '{default: 0};
    int ev_cyc[7] = '{default: 0};
    int n_multi = 0;
    logic retry_perr = 1'b0;
    logic [7:0] wr_data_q[$];
    int wr_cyc_q[$];
    int byte_cyc[8];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [6:0] st;
        st = {rx_commit, rx_rollback, tx_send_ack, tx_send_nak,
              tx_send_data, tx_pkt_release, tx_pkt_retry};
        for (int i = 0; i < 7; i++) begin
            if (st[6-i]) begin
                n_ev[i]++;
                ev_cyc[i] = cyc;
            end
        end
        if (rx_fifo_wr) begin
            wr_data_q.push_back(rx_fifo_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if ($countones({tx_send_ack, tx_send_nak, tx_send_data}) > 1) n_multi++;
        if (tx_pkt_retry) retry_perr = proto_err;
    end

    function automatic logic [27:0] delta(input int s[7]);
        logic [27:0] r;
        r = '0;
        for (int i = 0; i < 7; i++) r = {r[23:0], 4'(n_ev[i] - s[i])};
        return r;
    endfunction

    function automatic logic [27:0] mk(input int c, input int rb, input int a,
                                       input int n, input int d,
                                       input int rel, input int rt);
        return {4'(c), 4'(rb), 4'(a), 4'(n), 4'(d), 4'(rel), 4'(rt)};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tok(input logic i, input logic o);
        in_token = i;
        out_token = o;
        tick();
        in_token = 1'b0;
        out_token = 1'b0;
    endtask

    task automatic pulse_eop(input logic crc, output int dc);
        dc = cyc;
        eop_found = 1'b1;
        crc_err = crc;
        tick();
        eop_found = 1'b0;
        crc_err = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic full);
        byte_ready = 1'b1;
        data_byte = b;
        rx_fifo_full = full;
        tick();
        byte_ready = 1'b0;
        rx_fifo_full = 1'b0;
    endtask

    task automatic drive_out_body(input logic [7:0] b[8], input int n,
                                  input int fidx, input logic crc, output int ec);
        int d;
        pulse_eop(1'b0, d);
        tick();
        for (int i = 0; i < n; i++) begin
            byte_cyc[i] = cyc;
            send_byte(b[i], i == fidx);
            repeat ($urandom_range(0, 1)) tick();
        end
        pulse_eop(crc, ec);
        tick(2);
        if (!crc) begin
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        tick(2);
    endtask

    task automatic drive_out_pkt(input logic [7:0] b[8], input int n,
                                 input int fidx, input logic crc, output int ec);
        pulse_tok(1'b0, 1'b1);
        tick();
        drive_out_body(b, n, fidx, crc, ec);
    endtask

    task automatic start_in(input logic avail, output int ec, output int entry);
        pulse_tok(1'b1, 1'b0);
        tick();
        tx_data_avail = avail;
        pulse_eop(1'b0, ec);
        tick(3);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        entry = cyc;
        tx_data_avail = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (all_out !== 18'h0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=0", all_out);
        end
        out_token = 1'b1;
        byte_ready = 1'b1;
        eop_found = 1'b1;
        tick(3);
        checks++;
        if (all_out !== 18'h0) begin
            failures++;
            $display("FAIL reset_held got=%h exp=0", all_out);
        end
        out_token = 1'b0;
        byte_ready = 1'b0;
        eop_found = 1'b0;
        n_rst = 1'b1;
        tick(2);
    endtask

    task automatic test_out_clean;
        logic [7:0] b[8] = '{8'hC6, 8'h59, 8'hA9, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        int s[7];
        int w0, ec;
        s = n_ev;
        w0 = wr_data_q.size();
        drive_out_pkt(b, 3, -1, 1'b0, ec);
        checks++;
        if (wr_data_q.size() - w0 !== 3) begin
            failures++;
            $display("FAIL clean_wr_count got=%0d exp=3", wr_data_q.size() - w0);
        end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] got = 'x;
            int gc = -1;
            if (w0 + i < wr_data_q.size()) begin
                got = wr_data_q[w0+i];
                gc = wr_cyc_q[w0+i];
            end
            checks++;
            if (got !== b[i] || gc !== byte_cyc[i] + 1) begin
                failures++;
                $display("FAIL clean_wr%0d got=%h@%0d exp=%h@%0d",
                         i, got, gc, b[i], byte_cyc[i] + 1);
            end
        end
        checks++;
        if (delta(s) !== mk(1, 0, 1, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL clean_events got=%h exp=%h", delta(s), mk(1, 0, 1, 0, 0, 0, 0));
        end
        checks++;
        if (ev_cyc[0] !== ec + 1 || ev_cyc[2] !== ec + 1) begin
            failures++;
            $display("FAIL clean_resp_timing got=%0d/%0d exp=%0d", ev_cyc[0], ev_cyc[2], ec + 1);
        end
    endtask

    task automatic test_out_crc;
        logic [7:0] b[8] = '{8'hC6, 8'h59, 8'hA9, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        int s[7];
        int ec, ie, en;
        s = n_ev;
        drive_out_pkt(b, 3, -1, 1'b1, ec);
        checks++;
        if (delta(s) !== mk(0, 1, 0, 0, 0, 0, 0) || ev_cyc[1] !== ec + 1) begin
            failures++;
            $display("FAIL crc_rollback got=%h@%0d exp=%h@%0d",
                     delta(s), ev_cyc[1], mk(0, 1, 0, 0, 0, 0, 0), ec + 1);
        end
        s = n_ev;
        start_in(1'b0, ie, en);
        tick(3);
        checks++;
        if (delta(s) !== mk(0, 0, 0, 1, 0, 0, 0) || ev_cyc[3] !== ie + 1) begin
            failures++;
            $display("FAIL crc_then_idle got=%h@%0d exp=%h@%0d",
                     delta(s), ev_cyc[3], mk(0, 0, 0, 1, 0, 0, 0), ie + 1);
        end
    endtask

    task automatic test_out_overflow;
        logic [7:0] b[8] = '{8'hC6, 8'h59, 8'hA9, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        int s[7];
        int w0, ec;
        s = n_ev;
        w0 = wr_data_q.size();
        drive_out_pkt(b, 3, 1, 1'b0, ec);
        checks++;
        if (wr_data_q.size() - w0 !== 1 ||
            (wr_data_q.size() > w0 && wr_data_q[w0] !== 8'hC6)) begin
            failures++;
            $display("FAIL ovf_writes got_count=%0d exp=1 (C6)", wr_data_q.size() - w0);
        end
        checks++;
        if (delta(s) !== mk(0, 1, 0, 1, 0, 0, 0) ||
            ev_cyc[1] !== ec + 1 || ev_cyc[3] !== ec + 1) begin
            failures++;
            $display("FAIL ovf_events got=%h exp=%h", delta(s), mk(0, 1, 0, 1, 0, 0, 0));
        end
    endtask

    task automatic test_in_ack;
        int s[7];
        int ec, en, ac;
        s = n_ev;
        start_in(1'b1, ec, en);
        tick(100);
        ac = cyc;
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
        tick(3);
        checks++;
        if (delta(s) !== mk(0, 0, 0, 0, 1, 1, 0) ||
            ev_cyc[4] !== ec + 1 || ev_cyc[5] !== ac + 1) begin
            failures++;
            $display("FAIL in_ack got=%h exp=%h", delta(s), mk(0, 0, 0, 0, 1, 1, 0));
        end
        checks++;
        if (proto_err !== 1'b0) begin
            failures++;
            $display("FAIL in_ack_perr got=%b exp=0", proto_err);
        end
    endtask

    task automatic test_in_nack;
        int s[7];
        int ec, en;
        s = n_ev;
        start_in(1'b1, ec, en);
        tick(10);
        host_nack = 1'b1;
        tick();
        host_nack = 1'b0;
        tick(3);
        checks++;
        if (delta(s) !== mk(0, 0, 0, 0, 1, 0, 1) || proto_err !== 1'b0) begin
            failures++;
            $display("FAIL in_nack got=%h perr=%b exp=%h perr=0",
                     delta(s), proto_err, mk(0, 0, 0, 0, 1, 0, 1));
        end
    endtask

    task automatic test_in_timeout;
        logic [7:0] b[8] = '{8'h12, 8'h34, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        int s[7];
        int ec, en, oc;
        s = n_ev;
        start_in(1'b1, ec, en);
        for (int i = 0; i < 400 && n_ev[6] == s[6]; i++) tick();
        checks++;
        if (n_ev[6] == s[6]) begin
            failures++;
            $display("FAIL timeout_wait got=no_retry exp=retry");
        end else if (ev_cyc[6] - en !== 288 || retry_perr !== 1'b1) begin
            failures++;
            $display("FAIL timeout_timing got=%0d perr=%b exp=288 perr=1",
                     ev_cyc[6] - en, retry_perr);
        end
        tick(5);
        checks++;
        if (proto_err !== 1'b1) begin
            failures++;
            $display("FAIL perr_sticky got=%b exp=1", proto_err);
        end
        drive_out_pkt(b, 2, -1, 1'b0, oc);
        checks++;
        if (proto_err !== 1'b0) begin
            failures++;
            $display("FAIL perr_clear got=%b exp=0", proto_err);
        end
    endtask

    task automatic test_ack_wins;
        int s[7];
        int ec, en;
        s = n_ev;
        start_in(1'b1, ec, en);
        tick(287);
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
        tick(3);
        checks++;
        if (delta(s) !== mk(0, 0, 0, 0, 1, 1, 0) || proto_err !== 1'b0) begin
            failures++;
            $display("FAIL ack_wins got=%h perr=%b exp=%h perr=0",
                     delta(s), proto_err, mk(0, 0, 0, 0, 1, 1, 0));
        end
    endtask

    task automatic test_both_tokens;
        int s[7];
        int w0, d;
        s = n_ev;
        w0 = wr_data_q.size();
        pulse_tok(1'b1, 1'b1);
        checks++;
        if (proto_err !== 1'b1) begin
            failures++;
            $display("FAIL both_tok_perr got=%b exp=1", proto_err);
        end
        tick();
        pulse_eop(1'b0, d);
        tick();
        send_byte(8'h11, 1'b0);
        pulse_eop(1'b0, d);
        tick(3);
        checks++;
        if (delta(s) !== '0 || wr_data_q.size() !== w0) begin
            failures++;
            $display("FAIL both_tok_idle got=%h wr=%0d exp=0 wr=0",
                     delta(s), wr_data_q.size() - w0);
        end
    endtask

    task automatic test_abort;
        logic [7:0] b[8] = '{8'hA5, 8'h5A, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        int s[7];
        int ec;
        s = n_ev;
        pulse_tok(1'b1, 1'b0);
        tick(2);
        pulse_tok(1'b0, 1'b1);
        checks++;
        if (proto_err !== 1'b1) begin
            failures++;
            $display("FAIL abort_perr got=%b exp=1", proto_err);
        end
        tick();
        drive_out_body(b, 2, -1, 1'b0, ec);
        checks++;
        if (delta(s) !== mk(1, 0, 1, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL abort_replay got=%h exp=%h", delta(s), mk(1, 0, 1, 0, 0, 0, 0));
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b[8] = '{8'h3C, 8'hC3, 8'h7E, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        int s[7];
        int d, w0, ec;
        logic ok;
        pulse_tok(1'b0, 1'b1);
        tick();
        pulse_eop(1'b0, d);
        tick();
        send_byte(8'hC6, 1'b0);
        checks++;
        if (rx_fifo_wr !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre_wr got=%b exp=1", rx_fifo_wr);
        end
        s = n_ev;
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (all_out !== 18'h0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%h exp=0", all_out);
        end
        tick(2);
        n_rst = 1'b1;
        tick(3);
        checks++;
        if (delta(s) !== '0) begin
            failures++;
            $display("FAIL rst_mid_discard got=%h exp=0", delta(s));
        end
        s = n_ev;
        w0 = wr_data_q.size();
        drive_out_pkt(b, 3, -1, 1'b0, ec);
        ok = (wr_data_q.size() - w0 == 3);
        for (int i = 0; i < 3 && ok; i++) ok = (wr_data_q[w0+i] == b[i]);
        checks++;
        if (!ok || delta(s) !== mk(1, 0, 1, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL rst_mid_next got=%h wr=%0d exp=%h wr=3",
                     delta(s), wr_data_q.size() - w0, mk(1, 0, 1, 0, 0, 0, 0));
        end
    endtask

    task automatic test_random_out;
        for (int p = 0; p < 20; p++) begin
            logic [7:0] b[8];
            int s[7];
            int n, fidx, nw, w0, ec;
            logic crc, ovf, ok;
            n = $urandom_range(1, 8);
            for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
            fidx = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, n - 1);
            crc = ($urandom_range(0, 3) == 0);
            ovf = (fidx >= 0);
            nw = ovf ? fidx : n;
            s = n_ev;
            w0 = wr_data_q.size();
            drive_out_pkt(b, n, fidx, crc, ec);
            checks++;
            if (delta(s) !== mk(!crc && !ovf, crc || ovf, !crc && !ovf,
                                !crc && ovf, 0, 0, 0)) begin
                failures++;
                $display("FAIL rand%0d_events got=%h n=%0d fidx=%0d crc=%b",
                         p, delta(s), n, fidx, crc);
            end
            ok = (wr_data_q.size() - w0 == nw);
            for (int i = 0; i < nw && ok; i++) ok = (wr_data_q[w0+i] == b[i]);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rand%0d_writes got=%0d exp=%0d",
                         p, wr_data_q.size() - w0, nw);
            end
        end
    endtask

    initial begin
        test_reset();
        test_out_clean();
        test_out_crc();
        test_out_overflow();
        test_in_ack();
        test_in_nack();
        test_in_timeout();
        test_ack_wins();
        test_both_tokens();
        test_abort();
        test_reset_mid();
        test_random_out();
        checks++;
        if (n_multi !== 0) begin
            failures++;
            $display("FAIL one_send_per_cycle got=%0d exp=0", n_multi);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
